gcn_transform_engine: RTL
=========================

Name: gcn_transform_engine

Overview:
Multi-lane successor of the GCN feature-times-weight transformation stage. It computes the full product FM x WM of size FEATURE_ROWS x WEIGHT_COLS.
- Each group of NUM_LANES weight columns is cached once in a lane scratch pad.
- Each feature row is then streamed once per group, producing NUM_LANES dot products per feature read.
- The shared memory interface has a fixed, parametrised read latency.
- Results go into an internal register matrix, read row-wise by the downstream combination stage.

Parameters:
FEATURE_ROWS, 6, number of feature-matrix rows
WEIGHT_ROWS, 96, vector length (feature columns = weight rows)
WEIGHT_COLS, 3, number of weight-matrix columns
NUM_LANES, 2, weight columns computed in parallel (1..WEIGHT_COLS)
IN_DATA_WIDTH, 5, unsigned element width
DOT_PROD_WIDTH, 16, stored result width
ADDRESS_WIDTH, 13, memory address width
MEM_LATENCY, 1, cycles from read issue to data valid (>=1)
WEIGHT_BASE_ADDR, 0, address of weight column 0 (column c at base+c)
FEATURE_BASE_ADDR, 512, address of feature row 0 (row r at base+r)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  begin operation; sampled in IDLE or DONE
data_in  in  IN_DATA_WIDTH x WEIGHT_ROWS  memory read data
read_row  in  clog2(FEATURE_ROWS)  result row select
enable_read  out  1  memory read strobe, one cycle per read
read_address  out  ADDRESS_WIDTH  read address, valid while enable_read=1
busy  out  1  high in every state except IDLE and DONE
done_trans  out  1  level, high in DONE
FM_WM_Row  out  DOT_PROD_WIDTH x WEIGHT_COLS  result row read_row (combinational from registers)

Behaviour:
- Reset (async): state IDLE; enable_read=0, read_address=0, busy=0, done_trans=0; all counters, scratch pad and result matrix cleared to 0.
- Reset mid-operation aborts immediately; partial results are discarded (cleared).
- Groups: NUM_GROUPS=ceil(WEIGHT_COLS/NUM_LANES). Group g covers columns g*NUM_LANES .. min(WEIGHT_COLS,(g+1)*NUM_LANES)-1; lanes_g is the column count of group g. Lanes beyond WEIGHT_COLS issue no reads and perform no writes.
- Read timing: data_in is valid exactly MEM_LATENCY cycles after the cycle in which enable_read=1. A tag shift register of depth MEM_LATENCY carries the capture target (lane index or feature).
- IDLE: start=1 goes to REQ_W with group=0.
- REQ_W: lanes_g cycles, one weight read per cycle, back-to-back; address WEIGHT_BASE_ADDR+column; then WAIT_W.
- WAIT_W: MEM_LATENCY cycles while returning columns are captured into lane scratch pad slots; then REQ_F with row=0.
- REQ_F: 1 cycle; read address FEATURE_BASE_ADDR+row; then WAIT_F.
- WAIT_F: MEM_LATENCY cycles. In the last cycle the feature is valid and each active lane L writes dot(scratch[L], data_in) to result[row][col_L] at the clock edge.
- After WAIT_F:
  - row<FEATURE_ROWS-1: row++, go to REQ_F.
  - else if group<NUM_GROUPS-1: group++, go to REQ_W.
  - else go to DONE.
- DONE: done_trans=1 and results are held. start=1 restarts at REQ_W (done_trans drops the next cycle). start is ignored while busy.
- Cycle count: if start is sampled at edge 0, done_trans is high from cycle T=1+sum_g(lanes_g+MEM_LATENCY+FEATURE_ROWS*(1+MEM_LATENCY)). With defaults, T=30.
- Arithmetic: unsigned IN_DATA_WIDTH x IN_DATA_WIDTH products, summed at full width 2*IN_DATA_WIDTH+clog2(WEIGHT_ROWS). The sum is then reduced to DOT_PROD_WIDTH by truncation (keep LSBs) by default.
- read_address holds its last value when enable_read=0.
- read_row >= FEATURE_ROWS returns all zeros.

Optional Feature:
GCN_TRANSFORM_SAT_EN: when defined, a full-width sum above 2^DOT_PROD_WIDTH-1 is stored as 2^DOT_PROD_WIDTH-1. When undefined, the sum is truncated modulo 2^DOT_PROD_WIDTH.

Decomposition:
- Package gcn_transform_pkg:
  - state enum (IDLE, REQ_W, WAIT_W, REQ_F, WAIT_F, DONE)
  - full-width accumulator width function
  - NUM_GROUPS computation function
  - tag struct {is_feature, lane}
- One sub-module, gcn_lane_dot: one lane's combinational WEIGHT_ROWS-element dot product plus truncate/saturate. It is instantiated NUM_LANES times.

Test Plan:
- Defaults, all data_in elements =1 for weights and features -> every FM_WM_Row entry =96; done_trans rises at T=30; exactly 3+12+... = 15 enable_read pulses in total (3 weight + 12 feature).
- MEM_LATENCY=3, NUM_LANES=3, weights col c elements =c+1, feature row r elements =r -> result[r][c]=96*r*(c+1); T=1+(3+3+6*4)=31.
- All elements =31, defaults -> without GCN_TRANSFORM_SAT_EN entry=26720 (92256 mod 65536); with it entry=65535.
- Assert reset during the second group's WAIT_F -> outputs and all FM_WM_Row entries are 0 the same cycle; state IDLE; a subsequent start completes normally.
- Pulse start while busy (every cycle) -> ignored, T unchanged; start in DONE -> done_trans low next cycle, recompute matches.
- NUM_LANES=2, WEIGHT_COLS=3 -> group 1 issues one weight read (address 2), no lane-1 writes; read_row=6 returns zeros.

Source files
------------

// File: rtl/gcn_transform_pkg.sv
// Shared types and sizing helpers for the multi-lane GCN feature x weight transform engine.
// Optional build macro GCN_TRANSFORM_SAT_EN (saturating result store) is consumed in gcn_lane_dot.
package gcn_transform_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_W,
    WAIT_W,
    REQ_F,
    WAIT_F,
    DONE
  } state_t;

  localparam int TAG_LANE_W = 8;

  // Capture target carried alongside an outstanding memory read.
  typedef struct packed {
    logic                  is_feature;
    logic [TAG_LANE_W-1:0] lane;
  } tag_t;

  function automatic int acc_width(input int in_w, input int rows);
    return 2 * in_w + $clog2(rows);
  endfunction

  function automatic int num_groups(input int cols, input int lanes);
    return (cols + lanes - 1) / lanes;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcn_lane_dot.sv
// One lane's combinational dot product of a cached weight column with a feature row.
// Define GCN_TRANSFORM_SAT_EN to clamp oversized sums instead of truncating them.
module gcn_lane_dot
  import gcn_transform_pkg::*;
#(
  parameter int WEIGHT_ROWS    = 96,
  parameter int IN_DATA_WIDTH  = 5,
  parameter int DOT_PROD_WIDTH = 16
) (
  input  logic [WEIGHT_ROWS-1:0][IN_DATA_WIDTH-1:0] weight,
  input  logic [WEIGHT_ROWS-1:0][IN_DATA_WIDTH-1:0] feature,
  output logic [DOT_PROD_WIDTH-1:0]                 dot
);

  localparam int ACC_W = acc_width(IN_DATA_WIDTH, WEIGHT_ROWS);

  typedef logic [WEIGHT_ROWS-1:0][IN_DATA_WIDTH-1:0] vec_t;

`ifdef GCN_TRANSFORM_SAT_EN
  localparam int EXT_W = ((ACC_W > DOT_PROD_WIDTH) ? ACC_W : DOT_PROD_WIDTH) + 1;
  localparam logic [EXT_W-1:0] SAT_MAX =
    {{(EXT_W - DOT_PROD_WIDTH){1'b0}}, {DOT_PROD_WIDTH{1'b1}}};
`endif

  function automatic logic [ACC_W-1:0] dot_sum(input vec_t w, input vec_t f);
    logic [ACC_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < WEIGHT_ROWS; i++) begin
      acc = acc + ACC_W'(w[i]) * ACC_W'(f[i]);
    end
    return acc;
  endfunction

  function automatic logic [DOT_PROD_WIDTH-1:0] reduce_sum(input logic [ACC_W-1:0] s);
`ifdef GCN_TRANSFORM_SAT_EN
    if (EXT_W'(s) > SAT_MAX) begin
      return '1;
    end
`endif
    return DOT_PROD_WIDTH'(s);
  endfunction

  assign dot = reduce_sum(dot_sum(weight, feature));

endmodule

// File: rtl/gcn_transform_engine.sv
// Multi-lane FM x WM engine: caches NUM_LANES weight columns, streams every feature row per group.
// Build macro GCN_TRANSFORM_SAT_EN selects saturating (instead of truncating) result storage.
module gcn_transform_engine
  import gcn_transform_pkg::*;
#(
  parameter int FEATURE_ROWS      = 6,
  parameter int WEIGHT_ROWS       = 96,
  parameter int WEIGHT_COLS       = 3,
  parameter int NUM_LANES         = 2,
  parameter int IN_DATA_WIDTH     = 5,
  parameter int DOT_PROD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH     = 13,
  parameter int MEM_LATENCY       = 1,
  parameter int WEIGHT_BASE_ADDR  = 0,
  parameter int FEATURE_BASE_ADDR = 512
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [WEIGHT_ROWS-1:0][IN_DATA_WIDTH-1:0] data_in,
  input  logic [idx_width(FEATURE_ROWS)-1:0]        read_row,
  output logic                                      enable_read,
  output logic [ADDRESS_WIDTH-1:0]                  read_address,
  output logic                                      busy,
  output logic                                      done_trans,
  output logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] FM_WM_Row
);

  localparam int NUM_GROUPS = num_groups(WEIGHT_COLS, NUM_LANES);
  localparam int GRP_W      = idx_width(NUM_GROUPS);
  localparam int ROW_W      = idx_width(FEATURE_ROWS);
  localparam int LANE_W     = idx_width(NUM_LANES);
  localparam int WCNT_W     = idx_width(MEM_LATENCY);
  localparam int COL_W      = idx_width(WEIGHT_COLS);

  localparam logic [GRP_W-1:0]  GRP_LAST  = GRP_W'(NUM_GROUPS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_LANES - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_LATENCY - 1);

  typedef logic [WEIGHT_ROWS-1:0][IN_DATA_WIDTH-1:0]  vec_t;
  typedef logic [WEIGHT_COLS-1:0][DOT_PROD_WIDTH-1:0] res_row_t;

  state_t              state_q, state_d;
  logic [GRP_W-1:0]    grp_q, grp_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_hold_q, addr_hold_d;
  tag_t                tag_q [MEM_LATENCY];
  tag_t                tag_d [MEM_LATENCY];
  logic [MEM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  vec_t                scratch_q [NUM_LANES];
  vec_t                scratch_d [NUM_LANES];
  res_row_t            res_q [FEATURE_ROWS];
  res_row_t            res_d [FEATURE_ROWS];

  logic [DOT_PROD_WIDTH-1:0] dot [NUM_LANES];
  int                  col_base;
  logic                last_lane;
  logic                wait_last;
  tag_t                tag_in;
  tag_t                tag_tail;
  logic                tail_vld;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    gcn_lane_dot #(
      .WEIGHT_ROWS   (WEIGHT_ROWS),
      .IN_DATA_WIDTH (IN_DATA_WIDTH),
      .DOT_PROD_WIDTH(DOT_PROD_WIDTH)
    ) u_dot (
      .weight (scratch_q[l]),
      .feature(data_in),
      .dot    (dot[l])
    );
  end

  assign enable_read = (state_q == REQ_W) || (state_q == REQ_F);
  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done_trans  = (state_q == DONE);

  always_comb begin
    col_base  = int'(grp_q) * NUM_LANES;
    last_lane = (lane_q == LANE_LAST) || (col_base + int'(lane_q) == WEIGHT_COLS - 1);
    wait_last = (wcnt_q == WCNT_LAST);
  end

  // Address is live only in request states; otherwise the last issued one is held.
  always_comb begin
    read_address = addr_hold_q;
    if (state_q == REQ_W) begin
      read_address = ADDRESS_WIDTH'(WEIGHT_BASE_ADDR + col_base + int'(lane_q));
    end else if (state_q == REQ_F) begin
      read_address = ADDRESS_WIDTH'(FEATURE_BASE_ADDR + int'(row_q));
    end
    addr_hold_d = read_address;
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    row_d   = row_q;
    lane_d  = lane_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = REQ_W;
          grp_d   = '0;
          lane_d  = '0;
          row_d   = '0;
        end
      end
      REQ_W: begin
        if (last_lane) begin
          state_d = WAIT_W;
          wcnt_d  = '0;
        end else begin
          lane_d = lane_q + LANE_W'(1);
        end
      end
      WAIT_W: begin
        if (wait_last) begin
          state_d = REQ_F;
          row_d   = '0;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      REQ_F: begin
        state_d = WAIT_F;
        wcnt_d  = '0;
      end
      WAIT_F: begin
        if (wait_last) begin
          if (row_q != ROW_LAST) begin
            row_d   = row_q + ROW_W'(1);
            state_d = REQ_F;
          end else if (grp_q != GRP_LAST) begin
            grp_d   = grp_q + GRP_W'(1);
            lane_d  = '0;
            state_d = REQ_W;
          end else begin
            state_d = DONE;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipe: the tail entry marks the cycle in which data_in belongs to that read.
  always_comb begin
    tag_in.is_feature = (state_q == REQ_F);
    tag_in.lane       = TAG_LANE_W'(lane_q);
    tag_tail          = tag_q[MEM_LATENCY-1];
    tail_vld          = tag_vld_q[MEM_LATENCY-1];
    tag_d             = tag_q;
    tag_vld_d         = tag_vld_q;
    for (int i = MEM_LATENCY - 1; i > 0; i--) begin
      tag_d[i]     = tag_q[i-1];
      tag_vld_d[i] = tag_vld_q[i-1];
    end
    tag_d[0]     = tag_in;
    tag_vld_d[0] = enable_read;
  end

  always_comb begin
    scratch_d = scratch_q;
    res_d     = res_q;
    if (tail_vld && !tag_tail.is_feature) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (tag_tail.lane == TAG_LANE_W'(l)) begin
          scratch_d[l] = data_in;
        end
      end
    end
    if (tail_vld && tag_tail.is_feature) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (col_base + l < WEIGHT_COLS) begin
          res_d[row_q][COL_W'(col_base + l)] = dot[l];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grp_q       <= '0;
      row_q       <= '0;
      lane_q      <= '0;
      wcnt_q      <= '0;
      addr_hold_q <= '0;
      tag_q       <= '{default: '0};
      tag_vld_q   <= '0;
      scratch_q   <= '{default: '0};
      res_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      grp_q       <= grp_d;
      row_q       <= row_d;
      lane_q      <= lane_d;
      wcnt_q      <= wcnt_d;
      addr_hold_q <= addr_hold_d;
      tag_q       <= tag_d;
      tag_vld_q   <= tag_vld_d;
      scratch_q   <= scratch_d;
      res_q       <= res_d;
    end
  end

  always_comb begin
    FM_WM_Row = '0;
    if (int'(read_row) < FEATURE_ROWS) begin
      FM_WM_Row = res_q[read_row];
    end
  end

endmodule
